// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolution unit: the per-instruction
// prediction record carried from fetch to execute.
package bp_pkg;

  typedef struct packed {
    logic        valid;
    logic        pred_taken;
    logic [1:0]  pred;
    logic [31:0] target;
  } bp_meta_t;

  localparam logic [1:0]  PRED_WEAK_NT = 2'b01;
  localparam logic [31:0] PC_STEP      = 32'd4;

  localparam bp_meta_t META_EMPTY = '{
    valid:      1'b0,
    pred_taken: 1'b0,
    pred:       2'b00,
    target:     32'd0
  };

  // A tag miss is treated as not-taken and reports the configured miss state.
  function automatic bp_meta_t make_meta(input logic        hit,
                                         input logic [1:0]  pred,
                                         input logic [31:0] target,
                                         input logic [1:0]  miss_init);
    bp_meta_t m;
    m.valid      = 1'b1;
    m.pred_taken = hit & pred[1];
    m.pred       = hit ? pred : miss_init;
    m.target     = target;
    return m;
  endfunction

endpackage

// File: rtl/bp_meta_reg.sv
// One prediction-metadata pipeline stage. A flush empties the stage and beats a
// stall; a stall holds the current record.
module bp_meta_reg
  import bp_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     flush_i,
  input  logic     stall_i,
  input  bp_meta_t meta_i,
  output bp_meta_t meta_o
);

  bp_meta_t meta_q;
  bp_meta_t meta_d;

  // Next record: flush, then stall, then load.
  always_comb begin
    meta_d = meta_q;
    if (flush_i) begin
      meta_d = META_EMPTY;
    end else if (stall_i) begin
      meta_d = meta_q;
    end else begin
      meta_d = meta_i;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      meta_q <= META_EMPTY;
    end else begin
      meta_q <= meta_d;
    end
  end

  assign meta_o = meta_q;

endmodule

// File: rtl/branch_resolution_unit.sv
// Execute-stage branch resolution: checks the carried prediction against the
// resolved branch, updates the predictor, requests redirects and counts events.
module branch_resolution_unit
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter logic [1:0]  MISS_INIT = 2'b01
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [31:0]      pcF_i,
  input  logic             hitF_i,
  input  logic [1:0]       prediccionF_i,
  input  logic [31:0]      dirobjetivoF_i,
  input  logic             stallD_i,
  input  logic             flushD_i,
  input  logic             flushE_i,
  input  logic             branchE_i,
  input  logic             branch_takenE_i,
  input  logic [31:0]      dirsaltoE_i,
  input  logic [31:0]      pcE_i,
  output logic             we_o,
  output logic [1:0]       old_prediction_o,
  output logic             branch_taken_o,
  output logic             mispredict_o,
  output logic [31:0]      pc_redirect_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);

  bp_meta_t meta_f_s;
  bp_meta_t meta_d_s;
  bp_meta_t meta_e_s;
  logic     mis_cond_s;
  logic     unused_pcf_s;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  assign unused_pcf_s = ^pcF_i;
  assign meta_f_s     = make_meta(hitF_i, prediccionF_i, dirobjetivoF_i, MISS_INIT);

  bp_meta_reg u_reg_fd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flushD_i | mispredict_o),
    .stall_i (stallD_i),
    .meta_i  (meta_f_s),
    .meta_o  (meta_d_s)
  );

  bp_meta_reg u_reg_de (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flushE_i | mispredict_o),
    .stall_i (1'b0),
    .meta_i  (meta_d_s),
    .meta_o  (meta_e_s)
  );

  // Resolution of the record in E against the actual branch outcome.
  always_comb begin
    we_o             = meta_e_s.valid & branchE_i;
    old_prediction_o = meta_e_s.pred;
    branch_taken_o   = branch_takenE_i & meta_e_s.valid & branchE_i;
    if (branchE_i) begin
      mis_cond_s = (branch_takenE_i != meta_e_s.pred_taken) |
                   (branch_takenE_i & meta_e_s.pred_taken & (dirsaltoE_i != meta_e_s.target));
    end else begin
      mis_cond_s = meta_e_s.pred_taken;
    end
    mispredict_o = meta_e_s.valid & mis_cond_s;
    if (!mispredict_o) begin
      pc_redirect_o = 32'd0;
    end else if (branch_taken_o) begin
      pc_redirect_o = dirsaltoE_i;
    end else begin
      pc_redirect_o = pcE_i + PC_STEP;
    end
  end

  // Saturating event counters: stop at all-ones.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (we_o && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
    if (mispredict_o && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      branch_cnt_q <= {CNT_W{1'b0}};
      mis_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: directed vectors push expected
// E-stage responses; a negedge monitor pops one whenever we_o or mispredict_o is seen.
module tb_branch_resolution_unit;

  typedef struct {
    logic        we;
    logic [1:0]  old;
    logic        tk;
    logic        mis;
    logic [31:0] redir;
    logic [3:0]  bc;
    logic [3:0]  mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] pcF_i;
  logic        hitF_i;
  logic [1:0]  prediccionF_i;
  logic [31:0] dirobjetivoF_i;
  logic        stallD_i, flushD_i, flushE_i;
  logic        branchE_i, branch_takenE_i;
  logic [31:0] dirsaltoE_i, pcE_i;
  logic        we_o, branch_taken_o, mispredict_o;
  logic [1:0]  old_prediction_o;
  logic [31:0] pc_redirect_o;
  logic [3:0]  branch_count_o, mispredict_count_o;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  branch_resolution_unit #(.CNT_W(4), .MISS_INIT(2'b01)) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .pcF_i              (pcF_i),
    .hitF_i             (hitF_i),
    .prediccionF_i      (prediccionF_i),
    .dirobjetivoF_i     (dirobjetivoF_i),
    .stallD_i           (stallD_i),
    .flushD_i           (flushD_i),
    .flushE_i           (flushE_i),
    .branchE_i          (branchE_i),
    .branch_takenE_i    (branch_takenE_i),
    .dirsaltoE_i        (dirsaltoE_i),
    .pcE_i              (pcE_i),
    .we_o               (we_o),
    .old_prediction_o   (old_prediction_o),
    .branch_taken_o     (branch_taken_o),
    .mispredict_o       (mispredict_o),
    .pc_redirect_o      (pc_redirect_o),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic hit, input logic [1:0] pred, input logic [31:0] tgt);
    hitF_i = hit; prediccionF_i = pred; dirobjetivoF_i = tgt; pcF_i = tgt - 32'd8;
  endtask

  task automatic drive_e(input logic br, input logic tk, input logic [31:0] salto, input logic [31:0] pc);
    branchE_i = br; branch_takenE_i = tk; dirsaltoE_i = salto; pcE_i = pc;
  endtask

  task automatic push(input logic we, input logic [1:0] old, input logic tk, input logic mis,
                      input logic [31:0] redir, input logic [3:0] bc, input logic [3:0] mc);
    exp_t e;
    e.we = we; e.old = old; e.tk = tk; e.mis = mis; e.redir = redir; e.bc = bc; e.mc = mc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".we"},    {31'd0, we_o},           32'd0);
    chk({name, ".tk"},    {31'd0, branch_taken_o}, 32'd0);
    chk({name, ".mis"},   {31'd0, mispredict_o},   32'd0);
    chk({name, ".redir"}, pc_redirect_o,           32'd0);
    chk({name, ".bc"},    {28'd0, branch_count_o}, 32'd0);
    chk({name, ".mc"},    {28'd0, mispredict_count_o}, 32'd0);
  endtask

  // Monitor: every presented E response must match the oldest expectation.
  always @(negedge clk) begin
    if (we_o || mispredict_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: we=%0b mis=%0b old=%b redir=0x%0h, expected no output",
                 we_o, mispredict_o, old_prediction_o, pc_redirect_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (we_o !== e.we || old_prediction_o !== e.old || branch_taken_o !== e.tk ||
            mispredict_o !== e.mis || pc_redirect_o !== e.redir ||
            branch_count_o !== e.bc || mispredict_count_o !== e.mc) begin
          bad++;
          $display("FAIL e_response: got we=%0b old=%b tk=%0b mis=%0b redir=0x%0h bc=%0d mc=%0d, expected we=%0b old=%b tk=%0b mis=%0b redir=0x%0h bc=%0d mc=%0d",
                   we_o, old_prediction_o, branch_taken_o, mispredict_o, pc_redirect_o,
                   branch_count_o, mispredict_count_o,
                   e.we, e.old, e.tk, e.mis, e.redir, e.bc, e.mc);
        end
      end
    end
  end

  initial begin
    logic [3:0] m;
    reset_i = 1'b0;
    stallD_i = 1'b0; flushD_i = 1'b0; flushE_i = 1'b0;
    drive_f(1'b1, 2'b11, 32'h1234);
    drive_e(1'b1, 1'b1, 32'h55, 32'h10);

    // Reset held: nothing valid anywhere.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("reset");
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
    drive_f(1'b0, 2'b00, 32'h0);
    @(negedge clk);
    chk_quiet("post_reset");
    step();
    drive_e(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Miss at F, not-taken branch at E.
    drive_f(1'b0, 2'b11, 32'h999);
    step();
    drive_f(1'b0, 2'b00, 32'h0);
    step();
    drive_e(1'b1, 1'b0, 32'h300, 32'h100);
    push(1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);
    step();
    drive_e(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("bc_after_miss", {28'd0, branch_count_o}, 32'd1);
    step();

    // Taken branch to a different target; following records must be squashed.
    drive_f(1'b1, 2'b10, 32'h200);
    step();
    drive_f(1'b1, 2'b11, 32'h500);
    step();
    drive_e(1'b1, 1'b1, 32'h240, 32'h120);
    push(1'b1, 2'b10, 1'b1, 1'b1, 32'h240, 4'd1, 4'd0);
    step();
    drive_f(1'b0, 2'b00, 32'h0);
    drive_e(1'b1, 1'b0, 32'h0, 32'h130);
    step();
    step();
    drive_e(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Predicted-taken on a non-branch.
    drive_f(1'b1, 2'b11, 32'habc);
    step();
    drive_f(1'b0, 2'b00, 32'h0);
    step();
    drive_e(1'b0, 1'b1, 32'h999, 32'h80);
    push(1'b0, 2'b11, 1'b0, 1'b1, 32'h84, 4'd2, 4'd1);
    step();
    drive_e(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Stall D for two cycles with E flushed: the held record reaches E exactly once.
    drive_f(1'b1, 2'b10, 32'h600);
    step();
    drive_f(1'b0, 2'b00, 32'h0);
    stallD_i = 1'b1; flushE_i = 1'b1;
    step();
    step();
    stallD_i = 1'b0; flushE_i = 1'b0;
    step();
    drive_e(1'b1, 1'b1, 32'h600, 32'h140);
    push(1'b1, 2'b10, 1'b1, 1'b0, 32'h0, 4'd2, 4'd2);
    step();
    push(1'b1, 2'b01, 1'b1, 1'b1, 32'h600, 4'd3, 4'd2);
    step();
    drive_e(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Mispredict while D is stalled: the stalled record is dropped.
    drive_f(1'b1, 2'b11, 32'h700);
    step();
    step();
    drive_f(1'b0, 2'b00, 32'h0);
    stallD_i = 1'b1;
    drive_e(1'b0, 1'b0, 32'h0, 32'h40);
    push(1'b0, 2'b11, 1'b0, 1'b1, 32'h44, 4'd4, 4'd3);
    step();
    stallD_i = 1'b0;
    drive_e(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) step();

    // Sixteen mispredicts drive the 4-bit counter into saturation.
    m = 4'd4;
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 2'b11, 1'b0, 1'b1, 32'h1004, 4'd4, m);
      if (m != 4'hF) m = m + 4'd1;
    end
    drive_f(1'b1, 2'b11, 32'h800);
    drive_e(1'b0, 1'b0, 32'h0, 32'h1000);
    repeat (46) step();
    drive_f(1'b0, 2'b00, 32'h0);
    repeat (4) step();
    @(negedge clk);
    chk("mc_saturated", {28'd0, mispredict_count_o}, 32'hF);
    chk("bc_final", {28'd0, branch_count_o}, 32'd4);

    // Reset mid-operation drops an in-flight record and clears counters.
    step();
    drive_f(1'b1, 2'b11, 32'h900);
    step();
    reset_i = 1'b0;
    drive_f(1'b0, 2'b00, 32'h0);
    step();
    reset_i = 1'b1;
    @(negedge clk);
    chk_quiet("mid_reset");
    repeat (3) step();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("pending_expectations", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
